// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity sense and prescale floor.
// Used by the transmitter here and by the matching receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Prescale values below this are raised to it.
   localparam int unsigned MIN_PRESCALE = 4;

   // Parity bit from the reduction XOR of the payload and the parity sense.
   function automatic logic par_calc(input logic par_typ, input logic xor_red);
      return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter for the UART transmitter. The prescale is latched on
// load so mid-frame changes on the input have no effect; bit_tick marks the
// last cycle of every bit period while run is high.
module uart_tx_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned PRSC_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  run,
   input  logic [PRSC_WIDTH-1:0] prescale,
   output logic                  bit_tick
);

   logic [PRSC_WIDTH-1:0] prsc_q, prsc_d;
   logic [PRSC_WIDTH-1:0] cnt_q, cnt_d;
   logic [PRSC_WIDTH-1:0] prsc_clamped;

   // End-of-bit detect against the latched prescale.
   always_comb begin
      bit_tick = run & (cnt_q == (prsc_q - PRSC_WIDTH'(1)));
   end

   // Next prescale (clamped to the floor) and counter; counter restarts each bit.
   always_comb begin
      prsc_clamped = (prescale < PRSC_WIDTH'(MIN_PRESCALE)) ? PRSC_WIDTH'(MIN_PRESCALE) : prescale;
      prsc_d       = load ? prsc_clamped : prsc_q;
      if (load || !run || bit_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PRSC_WIDTH'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prsc_q <= PRSC_WIDTH'(MIN_PRESCALE);
         cnt_q  <= '0;
      end else begin
         prsc_q <= prsc_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit; each bit lasts Prescale clock cycles.
// Optional feature macro: UART_TX_HOLD_BUF_EN adds a one-entry holding
// register so a byte can be queued while a frame is in flight.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRSC_WIDTH = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRSC_WIDTH-1:0] Prescale,
   output logic                  TX_OUT,
   output logic                  Busy,
   output logic                  Tx_Done
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   tx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;

   logic                  bit_tick;
   logic                  tx_done;
   logic                  launch;
   logic                  accept;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  ld_par_en;
   logic                  ld_par_typ;
   logic [PRSC_WIDTH-1:0] ld_prsc;

   uart_tx_bit_timer #(
      .PRSC_WIDTH (PRSC_WIDTH)
   ) u_bit_timer (
      .clk      (CLK),
      .rst_n    (RST),
      .load     (launch),
      .run      (state_q != IDLE),
      .prescale (ld_prsc),
      .bit_tick (bit_tick)
   );

   // Last cycle of the stop bit.
   always_comb begin
      tx_done = (state_q == STOP) & bit_tick;
   end

`ifdef UART_TX_HOLD_BUF_EN
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_par_en_q, hold_par_en_d;
   logic                  hold_par_typ_q, hold_par_typ_d;
   logic [PRSC_WIDTH-1:0] hold_prsc_q, hold_prsc_d;
   logic                  launch_hold;
   logic                  launch_in;

   // Accepted bytes go straight out when idle, otherwise into the holding
   // register, which is drained into a new frame at the end of the current one.
   always_comb begin
      accept      = Data_Valid & ~hold_full_q;
      launch_hold = hold_full_q & ((state_q == IDLE) | tx_done);
      launch_in   = accept & (state_q == IDLE);
      launch      = launch_hold | launch_in;

      ld_data    = launch_hold ? hold_data_q    : P_DATA;
      ld_par_en  = launch_hold ? hold_par_en_q  : PAR_EN;
      ld_par_typ = launch_hold ? hold_par_typ_q : PAR_TYP;
      ld_prsc    = launch_hold ? hold_prsc_q    : Prescale;

      hold_full_d    = hold_full_q;
      hold_data_d    = hold_data_q;
      hold_par_en_d  = hold_par_en_q;
      hold_par_typ_d = hold_par_typ_q;
      hold_prsc_d    = hold_prsc_q;
      if (accept && !launch_in) begin
         hold_full_d    = 1'b1;
         hold_data_d    = P_DATA;
         hold_par_en_d  = PAR_EN;
         hold_par_typ_d = PAR_TYP;
         hold_prsc_d    = Prescale;
      end else if (launch_hold) begin
         hold_full_d = 1'b0;
      end

      Busy = hold_full_q;
   end

   // Holding register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hold_full_q    <= 1'b0;
         hold_data_q    <= '0;
         hold_par_en_q  <= 1'b0;
         hold_par_typ_q <= 1'b0;
         hold_prsc_q    <= '0;
      end else begin
         hold_full_q    <= hold_full_d;
         hold_data_q    <= hold_data_d;
         hold_par_en_q  <= hold_par_en_d;
         hold_par_typ_q <= hold_par_typ_d;
         hold_prsc_q    <= hold_prsc_d;
      end
   end
`else
   // Accept only when no frame is in progress; requests while busy are dropped.
   always_comb begin
      accept     = Data_Valid & (state_q == IDLE);
      launch     = accept;
      ld_data    = P_DATA;
      ld_par_en  = PAR_EN;
      ld_par_typ = PAR_TYP;
      ld_prsc    = Prescale;
      Busy       = (state_q != IDLE);
   end
`endif

   // Frame sequencing, payload shifting and parity capture.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      if (launch) begin
         state_d   = START;
         shift_d   = ld_data;
         idx_d     = '0;
         par_en_d  = ld_par_en;
         par_bit_d = par_calc(ld_par_typ, ^ld_data);
      end else begin
         case (state_q)
            START: begin
               if (bit_tick) begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                     state_d = par_en_q ? PARITY : STOP;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     shift_d = shift_q >> 1;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) state_d = STOP;
            end
            STOP: begin
               if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Serial line and completion pulse, decoded from registered state.
   always_comb begin
      case (state_q)
         START:   TX_OUT = 1'b0;
         DATA:    TX_OUT = shift_q[0];
         PARITY:  TX_OUT = par_bit_q;
         default: TX_OUT = 1'b1;
      endcase
      Tx_Done = tx_done;
   end

   // State registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: a line monitor decodes TX_OUT frames and
// compares them with a scoreboard queue filled when bytes are accepted.
module tb_uart_tx_serializer;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic [PW-1:0] Prescale;
   logic          TX_OUT;
   logic          Busy;
   logic          Tx_Done;

   always #5 CLK = ~CLK;

   uart_tx_serializer #(
      .DATA_WIDTH (DW),
      .PRSC_WIDTH (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy),
      .Tx_Done    (Tx_Done)
   );

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      logic [5:0] prsc;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      logic [5:0] prsc;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   frame_t sb_q[$];
   int     n_cmp  = 0;
   int     n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- line monitor ----------------
   int         cyc         = 0;
   bit         in_frame    = 0;
   bit         gap_check   = 0;
   int         t, p, nb, b, ph;
   int         stab_err, busy_err;
   logic       first_val;
   logic [11:0] got;
   frame_t     cur;
   int         frames_done = 0;
   int         last_len    = 0;
   logic       last_par    = 1'b0;
   logic [7:0] last_data   = 8'h00;
   int         last_done_cyc = 0;
   int         last_gap    = 0;

   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         if (RST !== 1'b1) begin
            in_frame  = 0;
            gap_check = 0;
         end else begin
            if (!in_frame) begin
`ifndef UART_TX_HOLD_BUF_EN
               if (gap_check) begin
                  check("idle_gap_tx", TX_OUT, 1'b1);
                  check("idle_gap_busy", Busy, 1'b0);
               end
`endif
               gap_check = 0;
               if (TX_OUT === 1'b0) begin
                  check("sb_nonempty", sb_q.size() != 0, 1'b1);
                  if (sb_q.size() != 0) cur = sb_q.pop_front();
                  else cur = '{8'h00, 1'b0, 1'b0, 6'd8};
                  p        = (cur.prsc < 4) ? 4 : int'(cur.prsc);
                  nb       = DW + 2 + int'(cur.par_en);
                  t        = 0;
                  stab_err = 0;
                  busy_err = 0;
                  got      = '0;
                  last_gap = cyc - last_done_cyc;
                  in_frame = 1;
               end else begin
                  check("done_while_idle", Tx_Done, 1'b0);
               end
            end
            if (in_frame) begin
               b  = t / p;
               ph = t % p;
               if (ph == 0) first_val = TX_OUT;
               else if (TX_OUT !== first_val) stab_err++;
               if (ph == p / 2 && b < 12) got[b] = TX_OUT;
`ifndef UART_TX_HOLD_BUF_EN
               if (Busy !== 1'b1) busy_err++;
`endif
               if (Tx_Done === 1'b1) begin
                  check("start_bit", got[0], 1'b0);
                  check("data", got[8:1], cur.data);
                  if (cur.par_en)
                     check("parity", got[9], cur.par_typ ? ~^cur.data : ^cur.data);
                  check("stop_bit", got[nb-1], 1'b1);
                  check("frame_len", t + 1, nb * p);
                  check("bit_stability", stab_err, 0);
`ifndef UART_TX_HOLD_BUF_EN
                  check("busy_in_frame", busy_err, 0);
`endif
                  last_len      = t + 1;
                  last_par      = got[9];
                  last_data     = got[8:1];
                  last_done_cyc = cyc;
                  frames_done++;
                  in_frame  = 0;
                  gap_check = 1;
               end else if (t > 64 * 14) begin
                  check("frame_timeout", t, nb * p);
                  frames_done++;
                  in_frame = 0;
               end
               t++;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
      int k = 0;
      while (Busy !== 1'b0 && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      check("send_wait_bounded", k < 3000, 1'b1);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Prescale   = ps;
      Data_Valid = 1'b1;
      sb_q.push_back('{d, pe, pt, ps});
      @(negedge CLK);
      Data_Valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int k = 0;
      while (frames_done < target && k < 5000) begin
         @(negedge CLK);
         k++;
      end
      check("frames_done", frames_done, target);
   endtask

   vec_t vecs[6];
   int   fd;

   initial begin
      vecs[0] = '{8'hBB, 1'b1, 1'b1, 6'd32, 1'b1, 352};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 6'd8,  1'b0, 80};
      vecs[2] = '{8'h01, 1'b1, 1'b0, 6'd16, 1'b1, 176};
      vecs[3] = '{8'hA5, 1'b1, 1'b0, 6'd8,  1'b0, 88};
      vecs[4] = '{8'h3C, 1'b1, 1'b1, 6'd4,  1'b1, 44};
      vecs[5] = '{8'h5A, 1'b0, 1'b0, 6'd2,  1'b0, 40};

      RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
      repeat (3) @(negedge CLK);
      check("rst_tx_out", TX_OUT, 1'b1);
      check("rst_busy", Busy, 1'b0);
      check("rst_tx_done", Tx_Done, 1'b0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // Table-driven single frames.
      for (int i = 0; i < 6; i++) begin
         fd = frames_done;
         send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].prsc);
         wait_frames(fd + 1);
         check("tbl_len", last_len, vecs[i].exp_len);
         check("tbl_data", last_data, vecs[i].data);
         if (vecs[i].par_en) check("tbl_par", last_par, vecs[i].exp_par);
         repeat (2) @(negedge CLK);
      end

      // Second request mid-frame.
      fd = frames_done;
      send(8'hA5, 1'b1, 1'b0, 6'd8);
      repeat (20) @(negedge CLK);
`ifdef UART_TX_HOLD_BUF_EN
      send(8'h55, 1'b1, 1'b0, 6'd8);
      check("hold_busy", Busy, 1'b1);
      wait_frames(fd + 2);
      check("b2b_gap", last_gap, 1);
      check("b2b_data", last_data, 8'h55);
`else
      check("busy_mid_frame", Busy, 1'b1);
      P_DATA = 8'h55; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      wait_frames(fd + 1);
      check("kept_first", last_data, 8'hA5);
      repeat (150) @(negedge CLK);
      check("no_extra_frame", frames_done, fd + 1);
`endif
      repeat (3) @(negedge CLK);

      // Reset during data bit 3, then a clean frame.
      fd = frames_done;
      send(8'hF0, 1'b0, 1'b0, 6'd8);
      repeat (36) @(negedge CLK);
      check("pre_rst_busy", Busy, 1'b1);
      #2 RST = 1'b0;
      #1;
      check("async_rst_tx", TX_OUT, 1'b1);
      check("async_rst_busy", Busy, 1'b0);
      check("async_rst_done", Tx_Done, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("post_rst_frames", frames_done, fd);
      send(8'h3C, 1'b1, 1'b0, 6'd8);
      wait_frames(fd + 1);
      check("post_rst_data", last_data, 8'h3C);
      repeat (3) @(negedge CLK);

      // Config change mid-frame.
      fd = frames_done;
      send(8'hC3, 1'b1, 1'b1, 6'd32);
      Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      wait_frames(fd + 1);
      check("cfg_f1_len", last_len, 352);
      send(8'h5A, 1'b0, 1'b0, 6'd8);
      wait_frames(fd + 2);
      check("cfg_f2_len", last_len, 80);
      check("cfg_f2_data", last_data, 8'h5A);
      repeat (5) @(negedge CLK);
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
